// File: rtl/led_ram_arbiter.sv
// led_ram_arbiter: shares the single-port LED frame-buffer RAM between the
// display scan engine (reads, priority) and the host loader (writes). A
// saturating wait counter bounds how long a pending host write can be starved.
//
// Build option: define LED_RAM_ARB_CLEAR_EN to include the clear engine, which
// zero-fills the whole RAM after an i_clear pulse. Without it, i_clear is
// ignored and o_busy is tied low; the port list is identical in both builds.
module led_ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // scan engine read port
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_ack,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  // host loader write port
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  // clear engine control
  input  logic                  i_clear,
  output logic                  o_busy,
  // data_ram port pins
  output logic                  o_mem_en,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT);

  // Arbitration terms (all combinational from current inputs and state)
  logic                  starve;      // writer has hit its denial limit
  logic                  rd_ack;
  logic                  wr_grant;
  logic                  clearing;    // clear engine owns the low-priority slot
  logic                  clr_blk;     // clear activity blocks the writer
  logic                  clr_grant;
  logic [ADDR_WIDTH-1:0] clr_wr_addr;

  // Control state
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  rd_vld_p1;   // read issued last cycle, data now on RAM output

`ifdef LED_RAM_ARB_CLEAR_EN
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;

  assign clearing    = (state == S_CLEAR);
  // A clear request in IDLE also holds off the writer for that cycle.
  assign clr_blk     = clearing || i_clear;
  // Reads preempt the clear; clr_addr simply waits for the next free cycle.
  assign clr_grant   = clearing && !rd_ack;
  assign clr_wr_addr = clr_addr;
  assign o_busy      = clearing;

  // Clear FSM: walks clr_addr over the full depth, advancing only on granted cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      clr_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_clear) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_grant) begin
            if (clr_addr == LAST_ADDR) begin
              state <= S_IDLE;
            end
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          clr_addr <= '0;
        end
      endcase
    end
  end
`else
  logic unused_clear;

  assign unused_clear = i_clear;
  assign clearing     = 1'b0;
  assign clr_blk      = 1'b0;
  assign clr_grant    = 1'b0;
  assign clr_wr_addr  = '0;
  assign o_busy       = 1'b0;
`endif

  // Priority: starved writer, reader, clear engine, normal writer.
  assign starve     = i_wr_valid && (wait_cnt == WAIT_TOP) && !clr_blk;
  assign rd_ack     = i_rd_req && !starve;
  assign wr_grant   = i_wr_valid && !clr_blk && (starve || !i_rd_req);

  assign o_rd_ack   = rd_ack;
  assign o_wr_ready = wr_grant;

  // Starvation counter: counts consecutive denied write cycles, frozen while clearing
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt <= '0;
    end else if (!clearing) begin
      if (!i_wr_valid || wr_grant) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_TOP) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Stage p0 -> p1: read valid follows the ack by one cycle (RAM read latency)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_ack;
    end
  end

  assign o_rd_valid = rd_vld_p1;
  assign o_rd_data  = i_mem_data;

  // RAM port mux: drive the pins from whichever requester holds the grant
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_wr_en = 1'b0;
    o_mem_addr  = '0;
    o_mem_data  = '0;
    if (wr_grant) begin
      o_mem_en    = 1'b1;
      o_mem_wr_en = 1'b1;
      o_mem_addr  = i_wr_addr;
      o_mem_data  = i_wr_data;
    end else if (rd_ack) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_rd_addr;
    end else if (clr_grant) begin
      o_mem_en    = 1'b1;
      o_mem_wr_en = 1'b1;
      o_mem_addr  = clr_wr_addr;
    end
  end

endmodule

// File: tb/tb_led_ram_arbiter.sv
// Bench for led_ram_arbiter: a RAM stand-in on the memory pins, a behavioural
// model of the arbitration rules checked every cycle, and directed scenarios
// with hand-computed expected values. Clear-engine scenarios are built when
// LED_RAM_ARB_CLEAR_EN is defined; otherwise i_clear must be ignored.
module tb_led_ram_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int MW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef LED_RAM_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          clr;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rd_req   (rd_req),
    .i_rd_addr  (rd_addr),
    .o_rd_ack   (rd_ack),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .i_wr_valid (wr_valid),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_wr_ready (wr_ready),
    .i_clear    (clr),
    .o_busy     (busy),
    .o_mem_en   (mem_en),
    .o_mem_wr_en(mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_wdata),
    .i_mem_data (mem_rdata)
  );

  // Single-port synchronous RAM stand-in (data_ram)
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  int            m_denied   = 0;   // consecutive cycles the pending write was refused
  bit            m_clearing = 1'b0;
  int            m_pos      = 0;   // next word the clear will zero
  bit            m_prev_ack = 1'b0;
  logic [DW-1:0] m_word     = '0;  // word the last accepted read must return
  bit            m_live     = 1'b0;
  bit            c_blk, c_starv, c_ack, c_rdy, c_clr;

  always @(negedge clk) begin
    c_blk   = m_clearing || (CLR_EN && clr);
    c_starv = wr_valid && (m_denied == MW) && !c_blk;
    c_ack   = rd_req && !c_starv;
    c_rdy   = wr_valid && !c_blk && (c_starv || !rd_req);
    c_clr   = m_clearing && !c_ack;
    if (m_live) begin
      chk("rd_ack", 64'(rd_ack), 64'(c_ack));
      chk("wr_ready", 64'(wr_ready), 64'(c_rdy));
      chk("busy", 64'(busy), 64'(m_clearing));
      chk("rd_valid", 64'(rd_valid), 64'(m_prev_ack));
      if (m_prev_ack) chk("rd_data", 64'(rd_data), 64'(m_word));
      chk("mem_en", 64'(mem_en), 64'(c_ack || c_rdy || c_clr));
      chk("mem_wr_en", 64'(mem_we), 64'(c_rdy || c_clr));
      if (c_rdy) begin
        chk("mem_addr wr", 64'(mem_addr), 64'(wr_addr));
        chk("mem_data wr", 64'(mem_wdata), 64'(wr_data));
      end else if (c_ack) begin
        chk("mem_addr rd", 64'(mem_addr), 64'(rd_addr));
      end else if (c_clr) begin
        chk("mem_addr clr", 64'(mem_addr), 64'(m_pos));
        chk("mem_data clr", 64'(mem_wdata), 64'd0);
      end
    end
    if (c_ack) m_word = m_mem[rd_addr];
    m_prev_ack = c_ack && !rst;
    if (c_rdy) m_mem[wr_addr] = wr_data;
    if (c_clr) m_mem[m_pos] = '0;
    if (rst) begin
      m_denied   = 0;
      m_clearing = 1'b0;
      m_pos      = 0;
      m_live     = 1'b1;
    end else if (m_clearing) begin
      if (c_clr) begin
        if (m_pos == DEPTH - 1) m_clearing = 1'b0;
        m_pos = (m_pos + 1) % DEPTH;
      end
    end else begin
      if (wr_valid && !c_rdy) m_denied = (m_denied < MW) ? m_denied + 1 : MW;
      else                    m_denied = 0;
      if (CLR_EN && clr) begin
        m_clearing = 1'b1;
        m_pos      = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    done     = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (wr_ready) done = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    chk("host_write completes", 64'(done), 64'd1);
  endtask

  task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    rd_req  = 1'b1;
    rd_addr = a;
    @(negedge clk);
    chk({nm, " ack"}, 64'(rd_ack), 64'd1);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk({nm, " valid"}, 64'(rd_valid), 64'd1);
    chk({nm, " data"}, 64'(rd_data), 64'(exp));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  denied, busy_n, rdy_n, reads;
    bit  found, toggle, run;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end
    mem_rdata = '0;
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset rd_valid", 64'(rd_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset mem_en", 64'(mem_en), 64'd0);
    chk("reset rd_ack", 64'(rd_ack), 64'd0);
    tick();

    // preload 0..3 with 0x10..0x13, then stream reads back-to-back
    for (int i = 0; i < 4; i++) host_write(AW'(i), DW'(32'h10 + i));
    for (int i = 0; i <= 4; i++) begin
      rd_req  = (i < 4);
      rd_addr = AW'(i);
      @(negedge clk);
      if (i < 4) chk("stream ack", 64'(rd_ack), 64'd1);
      if (i > 0) begin
        chk("stream valid", 64'(rd_valid), 64'd1);
        chk("stream data", 64'(rd_data), 64'(32'h10 + i - 1));
      end
      tick();
    end
    rd_req = 1'b0;

    // lone write is ready in the same cycle, then read back
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("lone write ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    read_check(6'd5, 32'hDEADBEEF, "readback 5");

    // starvation bound under a continuous reader
    rd_req = 1'b1; rd_addr = '0;
    wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 32'h77;
    denied = 0; found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        found = 1'b1;
        chk("starved grant blocks read", 64'(rd_ack), 64'd0);
      end else begin
        denied++;
      end
      tick();
    end
    wr_valid = 1'b0;
    chk("starved write granted", 64'(found), 64'd1);
    chk("starved denial count", 64'(denied), 64'd4);
    @(negedge clk);
    chk("reads resume", 64'(rd_ack), 64'd1);
    tick();
    rd_req = 1'b0;
    read_check(6'd7, 32'h77, "readback 7");

    // same-address read and write: reader sees old word
    host_write(6'd2, 32'h1);
    rd_req = 1'b1; rd_addr = 6'd2;
    wr_valid = 1'b1; wr_addr = 6'd2; wr_data = 32'h2;
    @(negedge clk);
    chk("collide ack", 64'(rd_ack), 64'd1);
    chk("collide write held", 64'(wr_ready), 64'd0);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("collide write next", 64'(wr_ready), 64'd1);
    chk("collide old data", 64'(rd_data), 64'h1);
    tick();
    wr_valid = 1'b0;
    read_check(6'd2, 32'h2, "collide new data");

`ifdef LED_RAM_ARB_CLEAR_EN
    // clear with no reads, writer pending throughout
    wr_valid = 1'b1; wr_addr = 6'd9; wr_data = 32'h99; clr = 1'b1;
    @(negedge clk);
    chk("write blocked by clear pulse", 64'(wr_ready), 64'd0);
    tick();
    clr = 1'b0;
    busy_n = 0; rdy_n = 0; run = 1'b1;
    for (int i = 0; i < 200 && run; i++) begin
      @(negedge clk);
      if (!busy) run = 1'b0;
      else begin
        busy_n++;
        if (wr_ready) rdy_n++;
      end
      tick();
    end
    wr_valid = 1'b0;
    chk("clear busy cycles", 64'(busy_n), 64'd64);
    chk("ready during clear", 64'(rdy_n), 64'd0);
    for (int i = 0; i <= DEPTH; i++) begin
      rd_req  = (i < DEPTH);
      rd_addr = AW'(i);
      @(negedge clk);
      if (i > 0) chk("cleared word", 64'(rd_data), (i - 1 == 9) ? 64'h99 : 64'h0);
      tick();
    end
    rd_req = 1'b0;

    // clear with a reader on every other cycle
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_n = 0; reads = 0; toggle = 1'b0; run = 1'b1;
    for (int i = 0; i < 300 && run; i++) begin
      rd_req  = busy && toggle;
      rd_addr = 6'd1;
      toggle  = !toggle;
      @(negedge clk);
      if (!busy) run = 1'b0;
      else begin
        busy_n++;
        if (rd_ack) reads++;
      end
      tick();
    end
    rd_req = 1'b0;
    chk("interleaved reads", 64'(reads), 64'd63);
    chk("interleaved clear length", 64'(busy_n), 64'(64 + reads));
    chk("interleaved total", 64'(busy_n), 64'd127);

    // reset when clr_addr reaches 20
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (20) tick();
    rst = 1'b1; rd_req = 1'b1; rd_addr = 6'd1;
    tick();
    rst = 1'b0; rd_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 32'h33;
    @(negedge clk);
    chk("post-reset busy", 64'(busy), 64'd0);
    chk("post-reset rd_valid", 64'(rd_valid), 64'd0);
    chk("post-reset write ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    read_check(6'd3, 32'h33, "post-reset readback");
    read_check(6'd25, 32'h0, "untouched word");
`else
    // i_clear has no effect without the clear engine
    wr_valid = 1'b1; wr_addr = 6'd10; wr_data = 32'hA; clr = 1'b1;
    @(negedge clk);
    chk("clear ignored ready", 64'(wr_ready), 64'd1);
    chk("clear ignored busy", 64'(busy), 64'd0);
    tick();
    clr = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("clear ignored busy after", 64'(busy), 64'd0);
    tick();
    read_check(6'd10, 32'hA, "readback 10");

    // reset with a read in flight
    rst = 1'b1; rd_req = 1'b1; rd_addr = 6'd1;
    tick();
    rst = 1'b0; rd_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 32'h33;
    @(negedge clk);
    chk("post-reset busy", 64'(busy), 64'd0);
    chk("post-reset rd_valid", 64'(rd_valid), 64'd0);
    chk("post-reset write ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    read_check(6'd3, 32'h33, "post-reset readback");
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
